// File: rtl/branch_history_table.sv
`default_nettype none
// ============================================================================
//  Module      : branch_history_table
//  Description : PC-indexed table of 2-bit saturating direction counters.
//                Registered taken/not-taken prediction one cycle after a
//                lookup, training from resolved branches, a post-reset
//                clearing sweep, and saturating branch/mispredict statistics.
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_history_table #(
    parameter int PC_WIDTH   = 32,
    parameter int INDEX_BITS = 6,
    parameter int STAT_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  lookup_valid,
    input  logic [PC_WIDTH-1:0]   lookup_pc,
    output logic                  predict_valid,
    output logic                  predict_taken,
    input  logic                  update_valid,
    input  logic [PC_WIDTH-1:0]   update_pc,
    input  logic                  update_taken,
    input  logic                  update_predicted,
    output logic                  init_busy,
    input  logic                  stats_clear,
    output logic [STAT_WIDTH-1:0] branch_cnt,
    output logic [STAT_WIDTH-1:0] mispredict_cnt
);

    localparam int                    c_entries  = 2 ** INDEX_BITS;
    localparam logic [INDEX_BITS-1:0] c_ptr_last = '1;
    localparam logic [INDEX_BITS-1:0] c_ptr_one  = {{(INDEX_BITS-1){1'b0}}, 1'b1};
    localparam logic [STAT_WIDTH-1:0] c_stat_max = '1;
    localparam logic [STAT_WIDTH-1:0] c_stat_one = {{(STAT_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [INDEX_BITS-1:0]   ptr_q, ptr_d;
    logic [1:0]              cnt_q [c_entries];
    logic [1:0]              cnt_d [c_entries];
    logic                    predict_valid_q, predict_valid_d;
    logic                    predict_taken_q, predict_taken_d;
    logic [STAT_WIDTH-1:0]   branch_cnt_q, branch_cnt_d;
    logic [STAT_WIDTH-1:0]   mispredict_cnt_q, mispredict_cnt_d;

    logic [INDEX_BITS-1:0]   w_lookup_idx;
    logic [INDEX_BITS-1:0]   w_update_idx;
    logic                    w_upd_accept;
    logic                    w_bypass;
    logic [1:0]              w_cur_cnt;
    logic [1:0]              w_new_cnt;
    logic                    w_unused_pc_bits;

    // Only the word-index bits of either PC select an entry; the rest alias.
    assign w_lookup_idx     = lookup_pc[INDEX_BITS+1:2];
    assign w_update_idx     = update_pc[INDEX_BITS+1:2];
    assign w_unused_pc_bits = ^{lookup_pc[PC_WIDTH-1:INDEX_BITS+2], lookup_pc[1:0],
                                update_pc[PC_WIDTH-1:INDEX_BITS+2], update_pc[1:0]};

    // Training is ignored until the clearing sweep has finished.
    assign w_upd_accept = update_valid && (state_q == ST_RUN);
    assign w_bypass     = w_upd_accept && lookup_valid && (w_lookup_idx == w_update_idx);
    assign w_cur_cnt    = cnt_q[w_update_idx];

    // Saturating step of the trained counter.
    always_comb begin
        w_new_cnt = w_cur_cnt;
        if (update_taken) begin
            if (w_cur_cnt != 2'b11) w_new_cnt = w_cur_cnt + 2'b01;
        end else begin
            if (w_cur_cnt != 2'b00) w_new_cnt = w_cur_cnt - 2'b01;
        end
    end

    // Sweep sequencing: walk every entry once, then run until reset.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        if (state_q == ST_INIT) begin
            ptr_d = ptr_q + c_ptr_one;
            if (ptr_q == c_ptr_last) state_d = ST_RUN;
        end
    end

    // Table write: sweep clears one entry per cycle, otherwise train.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == ST_INIT) begin
            cnt_d[ptr_q] = 2'b00;
        end else if (w_upd_accept) begin
            cnt_d[w_update_idx] = w_new_cnt;
        end
    end

    // Prediction: forced not-taken while sweeping; same-index training forwarded.
    always_comb begin
        predict_valid_d = lookup_valid;
        if (state_q == ST_INIT) begin
            predict_taken_d = 1'b0;
        end else if (w_bypass) begin
            predict_taken_d = w_new_cnt[1];
        end else begin
            predict_taken_d = cnt_q[w_lookup_idx][1];
        end
    end

    // Statistics: saturating increments, clear has priority.
    always_comb begin
        branch_cnt_d     = branch_cnt_q;
        mispredict_cnt_d = mispredict_cnt_q;
        if (stats_clear) begin
            branch_cnt_d     = '0;
            mispredict_cnt_d = '0;
        end else if (w_upd_accept) begin
            if (branch_cnt_q != c_stat_max) branch_cnt_d = branch_cnt_q + c_stat_one;
            if ((update_taken != update_predicted) && (mispredict_cnt_q != c_stat_max))
                mispredict_cnt_d = mispredict_cnt_q + c_stat_one;
        end
    end

    // Control, prediction and statistics registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= ST_INIT;
            ptr_q            <= '0;
            predict_valid_q  <= 1'b0;
            predict_taken_q  <= 1'b0;
            branch_cnt_q     <= '0;
            mispredict_cnt_q <= '0;
        end else begin
            state_q          <= state_d;
            ptr_q            <= ptr_d;
            predict_valid_q  <= predict_valid_d;
            predict_taken_q  <= predict_taken_d;
            branch_cnt_q     <= branch_cnt_d;
            mispredict_cnt_q <= mispredict_cnt_d;
        end
    end

    // Counter storage; contents are defined by the sweep, not by reset.
    always_ff @(posedge clk) begin
        cnt_q <= cnt_d;
    end

    assign predict_valid  = predict_valid_q;
    assign predict_taken  = predict_taken_q;
    assign init_busy      = (state_q == ST_INIT);
    assign branch_cnt     = branch_cnt_q;
    assign mispredict_cnt = mispredict_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_branch_history_table.sv
`default_nettype none
// ============================================================================
//  Module      : tb_branch_history_table
//  Description : Directed self-checking bench for branch_history_table
//                (INDEX_BITS=6, STAT_WIDTH=4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_history_table;

    localparam int PC_WIDTH   = 32;
    localparam int INDEX_BITS = 6;
    localparam int STAT_WIDTH = 4;
    localparam int STAT_MAX   = 15;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  lookup_valid;
    logic [PC_WIDTH-1:0]   lookup_pc;
    logic                  predict_valid;
    logic                  predict_taken;
    logic                  update_valid;
    logic [PC_WIDTH-1:0]   update_pc;
    logic                  update_taken;
    logic                  update_predicted;
    logic                  init_busy;
    logic                  stats_clear;
    logic [STAT_WIDTH-1:0] branch_cnt;
    logic [STAT_WIDTH-1:0] mispredict_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int exp_br   = 0;
    int exp_mp   = 0;

    branch_history_table #(
        .PC_WIDTH   (PC_WIDTH),
        .INDEX_BITS (INDEX_BITS),
        .STAT_WIDTH (STAT_WIDTH)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .lookup_valid     (lookup_valid),
        .lookup_pc        (lookup_pc),
        .predict_valid    (predict_valid),
        .predict_taken    (predict_taken),
        .update_valid     (update_valid),
        .update_pc        (update_pc),
        .update_taken     (update_taken),
        .update_predicted (update_predicted),
        .init_busy        (init_busy),
        .stats_clear      (stats_clear),
        .branch_cnt       (branch_cnt),
        .mispredict_cnt   (mispredict_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are stable 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        lookup_valid     = 1'b0;
        lookup_pc        = '0;
        update_valid     = 1'b0;
        update_pc        = '0;
        update_taken     = 1'b0;
        update_predicted = 1'b0;
        stats_clear      = 1'b0;
    endtask

    // One accepted training update (RUN state), tracked by the stats model.
    task automatic do_update(input logic [31:0] pc, input logic taken, input logic pred);
        update_valid     = 1'b1;
        update_pc        = pc;
        update_taken     = taken;
        update_predicted = pred;
        tick();
        idle_inputs();
        if (exp_br < STAT_MAX) exp_br++;
        if (taken != pred && exp_mp < STAT_MAX) exp_mp++;
    endtask

    task automatic do_lookup(input string tag, input logic [31:0] pc, input logic exp_taken);
        lookup_valid = 1'b1;
        lookup_pc    = pc;
        tick();
        idle_inputs();
        check({tag, "_valid"}, {31'b0, predict_valid}, 32'd1);
        check(tag, {31'b0, predict_taken}, {31'b0, exp_taken});
    endtask

    // Count cycles of init_busy, with lookups/updates hammering during the sweep.
    task automatic run_sweep(input string tag);
        int n;
        n = 0;
        while (init_busy && n < 200) begin
            lookup_valid     = 1'b1;
            lookup_pc        = 32'h0000_0100 + (n << 2);
            update_valid     = 1'b1;
            update_pc        = 32'h0000_0100;
            update_taken     = 1'b1;
            update_predicted = 1'b0;
            tick();
            n++;
            if (predict_taken !== 1'b0) check({tag, "_sweep_taken"}, {31'b0, predict_taken}, 32'd0);
        end
        idle_inputs();
        check({tag, "_sweep_cycles"}, n, 32'd64);
        check({tag, "_sweep_pvalid"}, {31'b0, predict_valid}, 32'd1);
        check({tag, "_sweep_taken_last"}, {31'b0, predict_taken}, 32'd0);
        check({tag, "_sweep_branch_cnt"}, {28'b0, branch_cnt}, 32'd0);
        check({tag, "_sweep_mp_cnt"}, {28'b0, mispredict_cnt}, 32'd0);
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        tick();
        // Reset state
        check("rst_pvalid", {31'b0, predict_valid}, 32'd0);
        check("rst_ptaken", {31'b0, predict_taken}, 32'd0);
        check("rst_busy", {31'b0, init_busy}, 32'd1);
        check("rst_branch", {28'b0, branch_cnt}, 32'd0);
        check("rst_mp", {28'b0, mispredict_cnt}, 32'd0);
        rst = 1'b0;

        // 1. Initial sweep: 64 cycles, dropped updates, forced not-taken
        run_sweep("init");
        tick();
        check("idle_pvalid", {31'b0, predict_valid}, 32'd0);

        // 2. Count up at 0x100 (index 0): 01,10,11,11
        do_update(32'h100, 1'b1, 1'b1);
        do_lookup("up1", 32'h100, 1'b0);
        do_update(32'h100, 1'b1, 1'b0);
        do_lookup("up2", 32'h100, 1'b1);
        do_update(32'h100, 1'b1, 1'b1);
        do_lookup("up3", 32'h100, 1'b1);
        do_update(32'h100, 1'b1, 1'b1);
        do_lookup("up4_sat", 32'h100, 1'b1);
        check("t2_branch", {28'b0, branch_cnt}, exp_br);
        check("t2_mp", {28'b0, mispredict_cnt}, exp_mp);

        // 3. Count down: 10,01,00,00 (floor, no wrap to 11)
        do_update(32'h100, 1'b0, 1'b1);
        do_lookup("dn1", 32'h100, 1'b1);
        do_update(32'h100, 1'b0, 1'b1);
        do_lookup("dn2", 32'h100, 1'b0);
        do_update(32'h100, 1'b0, 1'b0);
        do_lookup("dn3", 32'h100, 1'b0);
        do_update(32'h100, 1'b0, 1'b0);
        do_lookup("dn4_floor", 32'h100, 1'b0);

        // 4. Bypass at 0x200 (aliases index 0, cnt 00 -> 01, then 01 -> 10 same cycle)
        do_update(32'h200, 1'b1, 1'b0);
        do_lookup("byp_pre", 32'h200, 1'b0);
        update_valid     = 1'b1;
        update_pc        = 32'h200;
        update_taken     = 1'b1;
        update_predicted = 1'b0;
        lookup_valid     = 1'b1;
        lookup_pc        = 32'h200;
        tick();
        idle_inputs();
        if (exp_br < STAT_MAX) exp_br++;
        if (exp_mp < STAT_MAX) exp_mp++;
        check("bypass_taken", {31'b0, predict_taken}, 32'd1);

        // 5. Aliasing: 0x004 / 0x104 / 0xFFFF0004 share index 1; 0x008 is index 2
        do_update(32'h004, 1'b1, 1'b0);
        do_update(32'h004, 1'b1, 1'b0);
        do_lookup("alias_104", 32'h104, 1'b1);
        do_lookup("alias_hi", 32'hFFFF_0007, 1'b1);
        do_lookup("alias_008", 32'h008, 1'b0);
        check("t5_branch", {28'b0, branch_cnt}, exp_br);
        check("t5_mp", {28'b0, mispredict_cnt}, exp_mp);

        // 6. Stats saturation, clear priority, reset mid-run
        stats_clear = 1'b1;
        tick();
        idle_inputs();
        exp_br = 0;
        exp_mp = 0;
        check("clr_branch", {28'b0, branch_cnt}, 32'd0);
        for (int i = 0; i < 20; i++) do_update(32'h010, 1'b1, 1'b0);
        check("sat_branch", {28'b0, branch_cnt}, 32'd15);
        check("sat_mp", {28'b0, mispredict_cnt}, 32'd15);
        do_update(32'h010, 1'b0, 1'b0);
        do_update(32'h010, 1'b0, 1'b1);
        update_valid     = 1'b1;
        update_pc        = 32'h010;
        update_taken     = 1'b1;
        update_predicted = 1'b0;
        stats_clear      = 1'b1;
        tick();
        idle_inputs();
        check("clr_win_branch", {28'b0, branch_cnt}, 32'd0);
        check("clr_win_mp", {28'b0, mispredict_cnt}, 32'd0);
        do_update(32'h010, 1'b1, 1'b0);
        check("post_clr_branch", {28'b0, branch_cnt}, 32'd1);
        check("post_clr_mp", {28'b0, mispredict_cnt}, 32'd1);
        do_lookup("pre_rst_010", 32'h010, 1'b1);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst2_busy", {31'b0, init_busy}, 32'd1);
        check("rst2_branch", {28'b0, branch_cnt}, 32'd0);
        check("rst2_mp", {28'b0, mispredict_cnt}, 32'd0);
        run_sweep("rst2");
        do_lookup("rst2_010", 32'h010, 1'b0);
        do_lookup("rst2_004", 32'h004, 1'b0);
        do_lookup("rst2_200", 32'h200, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
